// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: status layout, FSM states and bit-timer helper.
package uart_tx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 32;

    typedef struct packed {
        logic overflow;
        logic full;
        logic empty;
        logic busy;
    } TXStatus_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } TXState_t;

    // Bit-timer reload value; dividers of 0 and 1 both give one cycle per bit.
    function automatic logic [DIV_W-1:0] bit_reload(input logic [DIV_W-1:0] div);
        return (div <= DIV_W'(1)) ? '0 : div - DIV_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Register-block side of the UART transmitter: byte writes, overflow clear, status and irq.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic [DATA_W-1:0] tx_d_i;
    logic              tx_d_valid_i;
    logic              ovf_clr_i;
    logic [31:0]       txirqmask_i;
    TXStatus_t         tx_status_o;
    logic              irq_o;

    modport master (
        output tx_d_i, tx_d_valid_i, ovf_clr_i, txirqmask_i,
        input  tx_status_o, irq_o
    );

    modport slave (
        input  tx_d_i, tx_d_valid_i, ovf_clr_i, txirqmask_i,
        output tx_status_o, irq_o
    );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with flush; shared by the UART TX and RX paths.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers register writes in a FIFO and serializes 8N/8E/8O frames with 1 or 2 stop bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_enable_i,
    input  logic [DIV_W-1:0] divider_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
    uart_tx_if.slave         bus,
    output logic             tx_o
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    TXState_t          state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [DIV_W-1:0]  timer_q, timer_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              par_en_q, par_en_d;
    logic              parity_q, parity_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count_unused;
    logic              mask_unused;
    logic              wr_req, timer_zero, start_frame;

    assign wr_req      = bus.tx_d_valid_i && tx_enable_i;
    assign fifo_push   = wr_req;
    assign timer_zero  = (timer_q == '0);
    assign mask_unused = ^bus.txirqmask_i[31:4];

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (bus.tx_d_i),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .flush (!tx_enable_i),
        .count (fifo_count_unused),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.tx_status_o = '{overflow: ovf_q, full: fifo_full, empty: fifo_empty,
                               busy: (state_q != TX_IDLE)};
    assign bus.irq_o = irq_q;
    assign tx_o      = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            timer_q    <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            timer_q    <= timer_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            parity_q   <= parity_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        timer_d     = timer_zero ? timer_q : timer_q - DIV_W'(1);
        div_d       = div_q;
        par_en_d    = par_en_q;
        parity_d    = parity_q;
        stop2_d     = stop2_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
        // Set beats clear; a drop while full is judged on the registered count.
        ovf_d       = (wr_req && fifo_full) || (ovf_q && !bus.ovf_clr_i);
        irq_d       = |(bus.tx_status_o & bus.txirqmask_i[3:0]);

        if (!tx_enable_i) begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    tx_d        = 1'b1;
                    start_frame = !fifo_empty;
                end
                TX_START: if (timer_zero) begin
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    timer_d   = bit_reload(div_q);
                end
                TX_DATA: if (timer_zero) begin
                    timer_d = bit_reload(div_q);
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = TX_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = TX_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
                TX_PARITY: if (timer_zero) begin
                    state_d    = TX_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    timer_d    = bit_reload(div_q);
                end
                TX_STOP: if (timer_zero) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                        timer_d    = bit_reload(div_q);
                    end else if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = TX_IDLE;
                    tx_d    = 1'b1;
                end
            endcase

            // Frame configuration is captured with the byte and held for the whole frame.
            if (start_frame) begin
                fifo_pop = 1'b1;
                shift_d  = fifo_dout;
                div_d    = divider_i;
                par_en_d = parity_en_i;
                parity_d = (^fifo_dout) ^ parity_odd_i;
                stop2_d  = stop2_i;
                timer_d  = bit_reload(divider_i);
                state_d  = TX_START;
                tx_d     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: expected frames are queued at write time and checked bit by bit on tx_o.
module tb_uart_tx;
    import uart_tx_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         par_en;
        bit         par_odd;
        bit         stop2;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_enable_i;
    logic [31:0] divider_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic        stop2_i;
    logic        tx_o;

    int n_tests = 0;
    int n_fail  = 0;
    sb_item_t sb_q[$];

    uart_tx_if bus ();

    uart_tx #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_enable_i  (tx_enable_i),
        .divider_i    (divider_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .bus          (bus),
        .tx_o         (tx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic put(input logic [7:0] d, input bit exp);
        sb_item_t it;
        @(posedge clk);
        #1;
        bus.tx_d_i       = d;
        bus.tx_d_valid_i = 1'b1;
        if (exp) begin
            it.data    = d;
            it.div     = int'(divider_i);
            it.par_en  = parity_en_i;
            it.par_odd = parity_odd_i;
            it.stop2   = stop2_i;
            sb_q.push_back(it);
        end
    endtask

    task automatic idle_bus();
        @(posedge clk);
        #1;
        bus.tx_d_valid_i = 1'b0;
    endtask

    // Pops the next expected frame and checks every cycle of it on tx_o.
    task automatic expect_frame(input int max_wait);
        sb_item_t   it;
        logic [11:0] bits;
        int nb, t, de;
        check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) return;
        it = sb_q.pop_front();
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = it.data[i];
        nb = 9;
        if (it.par_en) begin
            bits[nb] = (^it.data) ^ it.par_odd;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        if (it.stop2) begin
            bits[nb] = 1'b1;
            nb++;
        end
        de = (it.div <= 1) ? 1 : it.div;
        @(negedge clk);
        t = 0;
        while (tx_o !== 1'b0 && t < max_wait) begin
            @(negedge clk);
            t++;
        end
        check("frame_start", 32'(tx_o), 32'd0);
        if (tx_o !== 1'b0) return;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < de; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                check("frame_bit", 32'(tx_o), 32'(bits[b]));
                if (c == 0) check("frame_busy", 32'(bus.tx_status_o.busy), 32'd1);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        tx_enable_i      = 1'b1;
        divider_i        = 32'd4;
        parity_en_i      = 1'b0;
        parity_odd_i     = 1'b0;
        stop2_i          = 1'b0;
        bus.tx_d_i       = '0;
        bus.tx_d_valid_i = 1'b0;
        bus.ovf_clr_i    = 1'b0;
        bus.txirqmask_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_status", 32'(bus.tx_status_o), 32'h2);
        check("rst_irq", 32'(bus.irq_o), 32'd0);
        rst = 1'b0;

        // 0xA5, divider 4, even parity, one stop bit
        divider_i   = 32'd4;
        parity_en_i = 1'b1;
        put(8'hA5, 1'b1);
        idle_bus();
        expect_frame(20);
        @(negedge clk);
        check("a5_busy_after", 32'(bus.tx_status_o.busy), 32'd0);
        check("a5_tx_after", 32'(tx_o), 32'd1);

        // Back-to-back frames at divider 1, two stop bits
        divider_i   = 32'd1;
        parity_en_i = 1'b0;
        stop2_i     = 1'b1;
        put(8'h00, 1'b1);
        put(8'hFF, 1'b1);
        idle_bus();
        check("b2b_not_empty", 32'(bus.tx_status_o.empty), 32'd0);
        expect_frame(20);
        check("b2b_empty_after_pop2", 32'(bus.tx_status_o.empty), 32'd0);
        expect_frame(0);
        check("b2b_empty", 32'(bus.tx_status_o.empty), 32'd1);
        @(negedge clk);
        check("b2b_idle", 32'(bus.tx_status_o.busy), 32'd0);

        // Overflow: ten writes into an 8-deep FIFO while a slow frame runs
        divider_i       = 32'd100;
        stop2_i         = 1'b0;
        bus.txirqmask_i = 32'h8;
        for (int i = 0; i < 10; i++) put(8'(i + 16), i < 9);
        idle_bus();
        check("ovf_full", 32'(bus.tx_status_o.full), 32'd1);
        check("ovf_flag", 32'(bus.tx_status_o.overflow), 32'd1);
        check("ovf_busy", 32'(bus.tx_status_o.busy), 32'd1);
        @(posedge clk);
        #1;
        check("ovf_irq", 32'(bus.irq_o), 32'd1);
        bus.ovf_clr_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr_i = 1'b0;
        check("ovf_cleared", 32'(bus.tx_status_o.overflow), 32'd0);
        @(posedge clk);
        #1;
        check("ovf_irq_clr", 32'(bus.irq_o), 32'd0);
        check("ovf_still_full", 32'(bus.tx_status_o.full), 32'd1);
        tx_enable_i = 1'b0;
        @(posedge clk);
        #1;
        tx_enable_i = 1'b1;
        sb_q.delete();
        check("flush_empty", 32'(bus.tx_status_o.empty), 32'd1);
        check("flush_idle", 32'(bus.tx_status_o.busy), 32'd0);
        bus.txirqmask_i = '0;

        // Abort mid-DATA of 0x3C with two bytes queued
        divider_i = 32'd4;
        put(8'h3C, 1'b0);
        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        idle_bus();
        begin
            int t = 0;
            @(negedge clk);
            while (tx_o !== 1'b0 && t < 10) begin
                @(negedge clk);
                t++;
            end
        end
        check("abort_start", 32'(tx_o), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_bit1", 32'(tx_o), 32'd0);
        check("abort_queued", 32'(bus.tx_status_o.empty), 32'd0);
        @(posedge clk);
        #1;
        tx_enable_i = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tx", 32'(tx_o), 32'd1);
        check("abort_idle", 32'(bus.tx_status_o.busy), 32'd0);
        check("abort_empty", 32'(bus.tx_status_o.empty), 32'd1);
        put(8'h55, 1'b0);
        idle_bus();
        check("dis_ignored", 32'(bus.tx_status_o), 32'h2);
        repeat (3) @(posedge clk);
        #1;
        tx_enable_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reen_tx", 32'(tx_o), 32'd1);
        check("reen_status", 32'(bus.tx_status_o), 32'h2);

        // Divider and parity changed during a frame only affect the next frame
        divider_i    = 32'd4;
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b0;
        put(8'h5A, 1'b1);
        put(8'hC3, 1'b0);
        idle_bus();
        divider_i    = 32'd8;
        parity_odd_i = 1'b1;
        begin
            sb_item_t it;
            it.data    = 8'hC3;
            it.div     = 8;
            it.par_en  = 1'b1;
            it.par_odd = 1'b1;
            it.stop2   = 1'b0;
            sb_q.push_back(it);
        end
        expect_frame(20);
        expect_frame(0);
        @(negedge clk);
        check("div_idle", 32'(bus.tx_status_o.busy), 32'd0);

        // Asynchronous reset mid-frame
        bus.txirqmask_i = 32'h1;
        put(8'h81, 1'b1);
        idle_bus();
        repeat (12) @(negedge clk);
        check("pre_rst_irq", 32'(bus.irq_o), 32'd1);
        check("pre_rst_busy", 32'(bus.tx_status_o.busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_tx", 32'(tx_o), 32'd1);
        check("arst_status", 32'(bus.tx_status_o), 32'h2);
        check("arst_irq", 32'(bus.irq_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit stage of the UART IP, directly downstream of the register block. Accepts single-cycle byte write pulses from the TXDATA register, buffers them in a small FIFO, and serializes each byte onto the TX line. The frame format is start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits, with the bit period set by the programmed divider. Reports TX status and a masked interrupt back to the register block.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, ≥2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `tx_enable_i` in 1: transmitter enabled; derived from mode/master.
- `divider_i` in 32: clk cycles per bit; values 0 and 1 are treated as 1.
- `parity_en_i` in 1: append a parity bit.
- `parity_odd_i` in 1: 1 = odd parity, 0 = even parity.
- `stop2_i` in 1: 1 = two stop bits, 0 = one stop bit.
- `tx_d_i` in 8: byte to send.
- `tx_d_valid_i` in 1: single-cycle write pulse; there is no ready.
- `ovf_clr_i` in 1: pulse that clears the sticky overflow flag.
- `txirqmask_i` in 32: only bits [3:0] are used, one per status bit.
- `tx_o` out 1: serial line; idles high.
- `tx_status_o` out TXStatus_t: {overflow, full, empty, busy}.
- `irq_o` out 1: registered OR of (status[3:0] & mask[3:0]).

## Operation
- **FIFO write:** when `tx_d_valid_i` is high and `tx_enable_i` is high:
  - If FIFO count < `FIFO_DEPTH`, the byte is pushed.
  - Otherwise the byte is dropped and `overflow` is set. Fullness uses the registered count, so a push to a full FIFO is rejected even if a pop happens in the same cycle.
- A write while disabled is ignored: no push, no overflow.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** if the FIFO is not empty and the enable is high, pop into the shift register, load the bit counter, go to START.
  - **START:** `tx_o` = 0 for one bit period.
  - **DATA:** 8 bit periods; `tx_o` = shift[0], shift right each period.
  - **PARITY:** entered only if `parity_en_i`. Bit = XOR of the data bits, inverted when `parity_odd_i`.
  - **STOP:** `tx_o` = 1 for 1 or 2 periods. At the end:
    - If the FIFO is not empty and enabled, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- **Bit timer:** 32-bit down-counter, reloaded with max(`divider_i`,1)−1 at each bit start. `divider_i`, `parity_en_i`, `parity_odd_i` and `stop2_i` are sampled when the pop occurs and held for the whole frame, so changes mid-frame affect the next frame only.
- **Disable:** `tx_enable_i` low in any state aborts the frame and flushes the FIFO:
  - FSM → IDLE next cycle.
  - `tx_o` → 1 next cycle.
  - `overflow` is unchanged.
- **Status:**
  - `busy` = FSM ≠ IDLE.
  - `full` and `empty` come from the FIFO count.
  - `overflow` is sticky until `ovf_clr_i`. If set and clear occur in the same cycle, set wins.
- **Reset values:**
  - `tx_o` = 1.
  - FSM = IDLE.
  - FIFO empty.
  - `tx_status_o` = {0,0,1,0}.
  - `irq_o` = 0.

## Timing
- `tx_o` is driven from a flop.
- Valid pulse in cycle N with the FIFO empty and the FSM idle:
  - Push at the end of N.
  - Pop in N+1.
  - `tx_o` low from N+2.
- Each bit lasts exactly max(`divider_i`,1) cycles.
- Frame length in bit periods is 10 + `parity_en_i` + `stop2_i`.
- Back-to-back frames: the next start bit begins the cycle after the last stop-bit cycle.
- `busy` rises the cycle after the pop and falls the cycle after the last stop-bit cycle when no data remains.
- `irq_o` lags status by one cycle.
- A pop and a push may occur in the same cycle; the count is unchanged.

## Structure
- `uart_defs` gets:
  - `TXStatus_t` packed struct {overflow, full, empty, busy}; bit 0 = busy.
  - `TXState_t` enum {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}.
- Sub-module `uart_fifo`: synchronous FIFO parameterized by width/depth, with push, pop, flush, count, full and empty. It is reusable by the RX path.

## Test plan
- Divider=4, even parity, 1 stop, write 0xA5 → `tx_o` sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total; `busy` high throughout; low afterward.
- Divider=1, no parity, 2 stop, write 0x00 then 0xFF on consecutive cycles → two contiguous 11-cycle frames with no idle gap; `empty` returns to 1 after the second pop.
- `FIFO_DEPTH`=8, divider=100, write 10 bytes in consecutive cycles:
  - First byte is popped; 8 are stored; the 10th is dropped.
  - `full`=1 and `overflow`=1; `irq_o`=1 with mask=0x8.
  - `ovf_clr_i` clears `overflow`.
- Deassert `tx_enable_i` mid-DATA of 0x3C with 2 bytes queued → `tx_o`=1 and FSM IDLE next cycle; FIFO empty; subsequent writes while disabled are ignored.
- Change divider 4→8 during a frame → current frame stays at 4 cycles/bit; next frame uses 8.
- Assert `rst` mid-frame → `tx_o`=1, status={0,0,1,0}, and `irq_o`=0 immediately, without waiting for a clock edge.
